// File: rtl/regbank_sequencer_if.sv
// Command handshake bundle between control logic and the register-bank sequencer.
// The master drives the micro-op and valid; the slave returns ready.
interface regbank_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [WIDTH-1:0]  cmd_imm;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_rd,
    output cmd_rs1,
    output cmd_rs2,
    output cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_rd,
    input  cmd_rs1,
    input  cmd_rs2,
    input  cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/regbank_sequencer.sv
// Serialised micro-op initiator for the 2R/1W register bank:
// IDLE -> READ -> EXEC -> WRITE, one command per four cycles.
module regbank_sequencer #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  regbank_sequencer_if.slave cmd,
  output logic [ADDR_W-1:0] reg_addr_1,
  output logic [ADDR_W-1:0] reg_addr_2,
  input  logic [WIDTH-1:0]  reg_data_1,
  input  logic [WIDTH-1:0]  reg_data_2,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [WIDTH-1:0]  write_data,
  output logic [WIDTH-1:0]  result,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  state_t            state_q, state_d;
  logic              accept;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0]  imm_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  res_q;
  logic              zero_q, carry_q;
  logic [ADDR_W-1:0] wa_q;
  logic [WIDTH-1:0]  wd_q;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_carry;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;

  assign cmd.cmd_ready = (state_q == IDLE) && !rst;
  assign accept        = (state_q == IDLE) && cmd.cmd_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (cmd.cmd_valid) state_d = READ;
      READ:  state_d = EXEC;
      EXEC:  state_d = WRITE;
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= cmd.cmd_op;
      rd_q  <= cmd.cmd_rd;
      rs1_q <= cmd.cmd_rs1;
      rs2_q <= cmd.cmd_rs2;
      imm_q <= cmd.cmd_imm;
    end
  end

  // Read addresses come straight from the latched fields, so they
  // hold between commands without extra registers.
  assign reg_addr_1 = rs1_q;
  assign reg_addr_2 = rs2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state_q == READ) begin
      a_q <= reg_data_1;
      b_q <= reg_data_2;
    end
  end

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_MOV: alu_res = a_q;
      OP_LDI: alu_res = imm_q;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q   <= alu_res;
      zero_q  <= (alu_res == '0);
      carry_q <= alu_carry;
    end
  end

  assign result     = res_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;

  // Write port shows rd/result during WRITE and keeps them afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      wa_q <= '0;
      wd_q <= '0;
    end else if (state_q == WRITE) begin
      wa_q <= rd_q;
      wd_q <= res_q;
    end
  end

  assign done         = (state_q == WRITE);
  assign write_enable = (state_q == WRITE) && (rd_q != '0);
  assign write_addr   = (state_q == WRITE) ? rd_q : wa_q;
  assign write_data   = (state_q == WRITE) ? res_q : wd_q;

endmodule

// File: tb/tb_regbank_sequencer.sv
// Bench for regbank_sequencer: drives it against a behavioural 8x8 bank
// and compares every cycle with an op-level reference model.
module tb_regbank_sequencer;

  logic       test_clk;
  logic       rst;
  logic [2:0] reg_addr_1, reg_addr_2;
  logic [7:0] reg_data_1, reg_data_2;
  logic       write_enable;
  logic [2:0] write_addr;
  logic [7:0] write_data;
  logic [7:0] result;
  logic       flag_zero, flag_carry, done;

  regbank_sequencer_if #(.WIDTH(8), .ADDR_W(3)) cmd_bus ();

  regbank_sequencer #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk          (test_clk),
    .rst          (rst),
    .cmd          (cmd_bus.slave),
    .reg_addr_1   (reg_addr_1),
    .reg_addr_2   (reg_addr_2),
    .reg_data_1   (reg_data_1),
    .reg_data_2   (reg_data_2),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .result       (result),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .done         (done)
  );

  initial test_clk = 1'b0;
  always #5 test_clk = ~test_clk;

  // register bank: x0 reads zero, combinational reads, write on edge
  logic [7:0] bank [8];
  initial for (int i = 0; i < 8; i++) bank[i] = 8'h00;
  always @(posedge test_clk)
    if (write_enable && write_addr != 3'd0) bank[write_addr] <= write_data;
  assign reg_data_1 = (reg_addr_1 == 3'd0) ? 8'h00 : bank[reg_addr_1];
  assign reg_data_2 = (reg_addr_2 == 3'd0) ? 8'h00 : bank[reg_addr_2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int unsigned mdl_reg [8];
  int unsigned mdl_res, mdl_c, mdl_z;
  int unsigned p_res, p_c;
  int unsigned p_rd;
  int          phase;
  bit          just_done;
  int          n_acc;
  int          cyc;
  int          acc_cyc [$];

  function automatic void model_op(input int unsigned op, a, b, imm,
                                   output int unsigned r, c);
    r = 0;
    c = 0;
    case (op)
      0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin r = (a + 256 - b) % 256; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a;
      6: r = imm;
      default: r = (a < b) ? 1 : 0;
    endcase
  endfunction

  task automatic cycle(input logic v, input logic [2:0] op, rd, rs1, rs2,
                       input logic [7:0] imm);
    @(negedge test_clk);
    if (phase == 3) begin
      mdl_res = p_res;
      mdl_c   = p_c;
      mdl_z   = (p_res == 0) ? 1 : 0;
      if (p_rd != 0) mdl_reg[p_rd] = p_res;
      just_done = 1'b1;
    end
    chk("done", done, phase == 3);
    chk("write_enable", write_enable, (phase == 3) && (p_rd != 0));
    chk("cmd_ready", cmd_bus.cmd_ready, phase == 0);
    chk("result", result, mdl_res);
    chk("flag_zero", flag_zero, mdl_z);
    chk("flag_carry", flag_carry, mdl_c);
    if (phase == 3) begin
      chk("write_addr", write_addr, p_rd);
      chk("write_data", write_data, p_res);
    end
    if (phase == 0 && just_done) begin
      chk("bank_rd", bank[p_rd], mdl_reg[p_rd]);
      just_done = 1'b0;
    end
    cmd_bus.cmd_valid = v;
    cmd_bus.cmd_op    = op;
    cmd_bus.cmd_rd    = rd;
    cmd_bus.cmd_rs1   = rs1;
    cmd_bus.cmd_rs2   = rs2;
    cmd_bus.cmd_imm   = imm;
    if (phase == 0 && v) begin
      model_op(op, mdl_reg[rs1], mdl_reg[rs2], imm, p_res, p_c);
      p_rd  = rd;
      phase = 1;
      n_acc++;
      acc_cyc.push_back(cyc);
    end else if (phase != 0) begin
      phase = (phase == 3) ? 0 : phase + 1;
    end
    cyc++;
  endtask

  task automatic idle_rand();
    cycle(1'b0, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
          8'($urandom));
  endtask

  task automatic do_cmd(input logic [2:0] op, rd, rs1, rs2,
                        input logic [7:0] imm);
    cycle(1'b1, op, rd, rs1, rs2, imm);
    repeat (3) idle_rand();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    for (int i = 0; i < 8; i++) mdl_reg[i] = 0;
    mdl_res = 0; mdl_c = 0; mdl_z = 0;
    p_res = 0; p_c = 0; p_rd = 0;
    phase = 0; just_done = 0; n_acc = 0; cyc = 0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op  = '0;
    cmd_bus.cmd_rd  = '0;
    cmd_bus.cmd_rs1 = '0;
    cmd_bus.cmd_rs2 = '0;
    cmd_bus.cmd_imm = '0;

    rst = 1'b1;
    repeat (2) @(posedge test_clk);
    @(negedge test_clk);
    chk("rst_ready_low", cmd_bus.cmd_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_ready", cmd_bus.cmd_ready, 1'b1);
    chk("rst_we", write_enable, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_flags", {flag_zero, flag_carry}, 2'b00);

    do_cmd(3'd6, 3'd1, 3'd0, 3'd0, 8'hAA);
    do_cmd(3'd6, 3'd2, 3'd0, 3'd0, 8'h55);
    do_cmd(3'd0, 3'd3, 3'd1, 3'd2, 8'h00);
    idle_rand();
    chk("add_x3", bank[3], 8'hFF);
    chk("add_flags", {flag_zero, flag_carry}, 2'b00);

    do_cmd(3'd6, 3'd4, 3'd0, 3'd0, 8'hF0);
    do_cmd(3'd6, 3'd5, 3'd0, 3'd0, 8'h20);
    do_cmd(3'd0, 3'd6, 3'd4, 3'd5, 8'h00);
    idle_rand();
    chk("add_carry_x6", {flag_carry, bank[6]}, 9'h110);
    do_cmd(3'd1, 3'd7, 3'd5, 3'd4, 8'h00);
    idle_rand();
    chk("sub_borrow_x7", {flag_carry, bank[7]}, 9'h130);
    do_cmd(3'd1, 3'd7, 3'd1, 3'd1, 8'h00);
    idle_rand();
    chk("sub_zero", {flag_zero, flag_carry, bank[7]}, 10'h200);
    do_cmd(3'd7, 3'd7, 3'd5, 3'd4, 8'h00);
    idle_rand();
    chk("slt_x7", bank[7], 8'h01);

    do_cmd(3'd6, 3'd0, 3'd0, 3'd0, 8'h77);
    idle_rand();
    chk("x0_result", result, 8'h77);
    do_cmd(3'd5, 3'd1, 3'd0, 3'd0, 8'h00);
    idle_rand();
    chk("mov_x1_x0", bank[1], 8'h00);

    // valid held high with fields changing every cycle
    a0 = n_acc;
    acc_cyc.delete();
    repeat (12)
      cycle(1'b1, 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            8'($urandom));
    chk("bp_accepts", n_acc - a0, 3);
    if (acc_cyc.size() == 3) begin
      chk("bp_gap1", acc_cyc[1] - acc_cyc[0], 4);
      chk("bp_gap2", acc_cyc[2] - acc_cyc[1], 4);
    end
    idle_rand();

    // reset during EXEC drops the command
    do_cmd(3'd6, 3'd2, 3'd0, 3'd0, 8'h55);
    cycle(1'b1, 3'd6, 3'd2, 3'd0, 3'd0, 8'h99);
    cycle(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    @(negedge test_clk);
    chk("mid_exec_done", done, 1'b0);
    rst = 1'b1;
    @(negedge test_clk);
    chk("mid_rst_we", write_enable, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_result", result, 8'h00);
    rst = 1'b0;
    phase = 0; just_done = 0;
    mdl_res = 0; mdl_c = 0; mdl_z = 0;
    #1;
    chk("mid_rst_ready", cmd_bus.cmd_ready, 1'b1);
    repeat (4) idle_rand();
    chk("mid_rst_x2", bank[2], 8'h55);

    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) idle_rand();
      do_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             8'($urandom));
    end
    idle_rand();
    for (int i = 1; i < 8; i++) chk("final_bank", bank[i], mdl_reg[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks,
             n_errors);
    $finish;
  end

endmodule

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
Command-driven initiator for the 8x8-bit, 2-read/1-write register bank. Accepts one micro-operation per valid/ready handshake and drives both bank read ports. Executes an 8-bit ALU op on the read operands and writes the result back through the bank write port. Sits between the test/control logic and the register bank; the bank itself is unchanged.

Parameters:
WIDTH, 8, data width of bank registers and ALU.
ADDR_W, 3, register address width (2**ADDR_W registers; address 0 is hardwired zero in the bank).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_op  input  3  opcode.
cmd_rd  input  ADDR_W  destination register.
cmd_rs1  input  ADDR_W  source register 1.
cmd_rs2  input  ADDR_W  source register 2.
cmd_imm  input  WIDTH  immediate for LDI.
reg_addr_1  output  ADDR_W  to bank read port 1.
reg_addr_2  output  ADDR_W  to bank read port 2.
reg_data_1  input  WIDTH  from bank read port 1 (combinational read).
reg_data_2  input  WIDTH  from bank read port 2 (combinational read).
write_enable  output  1  to bank write enable.
write_addr  output  ADDR_W  to bank write address.
write_data  output  WIDTH  to bank write data.
result  output  WIDTH  last computed result.
flag_zero  output  1  last result == 0.
flag_carry  output  1  ADD carry-out / SUB borrow.
done  output  1  one-cycle pulse, command completing.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; result, flag_zero, flag_carry, all latched command fields = 0; write_enable=0, done=0. Bank contents are not touched.
- cmd_ready = (state==IDLE) && !rst. A handshake occurs at an edge where cmd_valid && cmd_ready. All cmd_* fields are latched at that edge; cmd_* changes while not IDLE are ignored.
- FSM: IDLE -> READ (on handshake) -> EXEC -> WRITE -> IDLE. Each non-IDLE state lasts exactly one cycle.
- Throughput: 1 command per 4 cycles. No back-to-back acceptance, because IDLE is always re-entered.
- READ: reg_addr_1=rs1, reg_addr_2=rs2; operands A=reg_data_1, B=reg_data_2 are registered at the end of the cycle.
- Outside READ: reg_addr_1/reg_addr_2 hold their latched values (0 after reset).
- EXEC: compute the op, then register result, flag_zero and flag_carry at the end of the cycle.
- Opcodes:
  - 000 ADD: {carry,result}=A+B.
  - 001 SUB: result=A-B mod 256; carry=(A<B unsigned).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 MOV: result=A.
  - 110 LDI: result=cmd_imm.
  - 111 SLT: result=(A<B unsigned)?1:0.
  - Logic/MOV/LDI/SLT: carry=0.
  - flag_zero=(result==0) for all ops.
- WRITE: write_addr=rd, write_data=result, write_enable=(rd!=0), done=1. The bank captures the data at the edge ending WRITE.
- Outside WRITE: write_enable=0 and done=0. write_addr/write_data hold their last values.
- rd==0: no write_enable pulse; done still pulses and result/flags still update.
- rs1==rd or rs2==rd: the sources are read before the write, so the pre-write value is used. No hazard exists because commands are serialised.
- Reset in any state: the next cycle is IDLE with write_enable=0. An in-flight command is dropped with no bank write and no done.
- result/flags persist until the next EXEC.

Test Plan:
Each scenario runs the block against the team's 8x8 register bank (bank reset driven as the inverse of rst); bank contents are checked via MOV or bank reads.
1. Reset: rst=1 for 2 cycles, then 0 -> cmd_ready=1, write_enable=0, done=0, result=0x00, flags=0.
2. LDI x1=0xAA; LDI x2=0x55; ADD x3=x1+x2 -> x3=0xFF, carry=0, zero=0. done rises exactly 3 cycles after each accepting edge, and write_enable is high only in that cycle.
3. Carry and borrow:
   - LDI x4=0xF0; LDI x5=0x20; ADD x6=x4+x5 -> x6=0x10, carry=1.
   - SUB x7=x5-x4 -> 0x30, carry=1.
   - SUB x7=x1-x1 -> 0x00, zero=1, carry=0.
   - SLT x7=x5,x4 -> 0x01.
4. x0 protection: LDI x0=0x77 -> write_enable never asserts, done pulses, result=0x77. Then MOV x1=x0 -> x1=0x00.
5. Backpressure: cmd_valid held high with 3 distinct commands, and cmd_* toggled mid-operation -> exactly one accept per 4 cycles. Only the fields present at each accepting edge take effect.
6. Reset mid-op: x2=0x55, issue LDI x2=0x99, assert rst for one cycle during EXEC -> no write_enable, no done, x2 still 0x55, cmd_ready=1 the cycle after rst falls.
